// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read port and the packed output stream for fifo_rd_packer.
// master = the packer, slave = the FIFO/downstream environment.
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);
  logic                         fifo_empty;
  logic                         fifo_rd_en;
  logic [DATA_WIDTH-1:0]        fifo_rd_data;
  logic [DATA_WIDTH*PACK-1:0]   out_data;
  logic [PACK-1:0]              out_keep;
  logic                         out_valid;
  logic                         out_ready;

  // A beat transfers on a rising clock edge where out_valid & out_ready; once
  // raised, out_valid and the payload stay put until that edge. The FIFO pop is
  // fifo_rd_en & ~fifo_empty at an edge, with data on fifo_rd_data the next cycle.
  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_data, out_keep, out_valid
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_data, out_keep, out_valid
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops PACK FIFO entries into one little-endian wide word on a
// valid/ready stream. Optional partial-word flush under FIFO_RD_PACK_FLUSH_EN.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                        rd_clk,
  input  logic                        rst_n,
`ifdef FIFO_RD_PACK_FLUSH_EN
  input  logic                        flush,
`endif
  fifo_rd_packer_if.master            bus,
  output logic [1:0]                  dbg_state,
  output logic [$clog2(PACK+1)-1:0]   dbg_fill
);
  localparam int            FW     = $clog2(PACK+1);
  localparam logic [FW:0]   PACK_W = (FW+1)'(PACK);
  localparam logic [FW-1:0] LAST   = FW'(PACK-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic                             run;
  logic                             inflight;
  logic [FW-1:0]                    fill;
  logic [1:0]                       state;
  logic [PACK-1:0][DATA_WIDTH-1:0]  acc;
  logic                             slot_free;
  logic                             hold_go;
  logic                             load;
  logic                             pop_block;
  logic [FW:0]                      occ;

  assign slot_free = ~bus.out_valid | bus.out_ready;
  assign hold_go   = (state == S_HOLD) & slot_free;

`ifdef FIFO_RD_PACK_FLUSH_EN
  logic            flush_pend;
  logic            flush_go;
  logic [PACK-1:0] part_keep;

  // Partial word leaves only once no pop is outstanding, so no byte is lost.
  assign flush_go  = flush_pend & ~inflight & (fill != '0) & (state != S_HOLD) & slot_free;
  assign pop_block = flush_pend;
  assign load      = hold_go | flush_go;

  always_comb begin
    part_keep = '0;
    for (int i = 0; i < PACK; i++) part_keep[i] = (FW'(i) < fill);
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
    end else if (flush) begin
      flush_pend <= 1'b1;
    end else if (~inflight & ((fill == '0) | load)) begin
      flush_pend <= 1'b0;
    end
  end
`else
  assign pop_block = 1'b0;
  assign load      = hold_go;
`endif

  // The HOLD exit empties the accumulator this edge, so a pop may issue in the
  // same cycle; this keeps throughput at PACK entries per PACK+1 cycles.
  assign occ = hold_go ? '0 : ({1'b0, fill} + {{FW{1'b0}}, inflight});
  assign bus.fifo_rd_en = run & ~bus.fifo_empty & (occ < PACK_W) & ~pop_block;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      fill     <= '0;
      state    <= S_IDLE;
      acc      <= '0;
    end else begin
      inflight <= bus.fifo_rd_en;
      if (load) begin
        acc   <= '0;
        fill  <= '0;
        state <= S_IDLE;
      end else if (inflight) begin
        for (int i = 0; i < PACK; i++) begin
          if (fill == FW'(i)) acc[i] <= bus.fifo_rd_data;
        end
        fill  <= fill + FW'(1);
        state <= (fill == LAST) ? S_HOLD : S_FILL;
      end
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_keep  <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= acc;
`ifdef FIFO_RD_PACK_FLUSH_EN
      bus.out_keep  <= hold_go ? {PACK{1'b1}} : part_keep;
`else
      bus.out_keep  <= {PACK{1'b1}};
`endif
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  assign dbg_state = state;
  assign dbg_fill  = fill;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DATA_WIDTH=8, PACK=4) with a behavioural
// FIFO, an expected-word queue and protocol monitors.
module tb_fifo_rd_packer;
  localparam int DW   = 8;
  localparam int PACK = 4;
  localparam int W    = 36;
  localparam int FW   = $clog2(PACK+1);

  logic          rd_clk = 1'b0;
  logic          rst_n  = 1'b0;
  logic [1:0]    dbg_state;
  logic [FW-1:0] dbg_fill;
`ifdef FIFO_RD_PACK_FLUSH_EN
  logic          flush  = 1'b0;
`endif

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PACK)) bus ();

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
`ifdef FIFO_RD_PACK_FLUSH_EN
    .flush     (flush),
`endif
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_fill  (dbg_fill)
  );

  // ---------------- clock ----------------
  always #5 rd_clk = ~rd_clk;

  // ---------------- behavioural FIFO ----------------
  logic [7:0] mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_rd_data <= mem[rd_ptr[7:0]];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pops = 0, beats = 0, last_beat_cyc = 0, prev_beat_cyc = 0;
  int proto_viol = 0, stab_viol = 0, quiet_viol = 0;
  bit quiet_watch = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(posedge rd_clk) cyc <= cyc + 1;

  // Out_ready driver: 0 = always ready, 1 = random stalls, 2 = held low.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge rd_clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge rd_clk) begin
    logic [W-1:0] e;
    if (bus.fifo_rd_en && bus.fifo_empty) proto_viol++;
    if (quiet_watch && (bus.out_valid || bus.fifo_rd_en)) quiet_viol++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                         bus.out_keep !== prev_keep)) stab_viol++;
      if (bus.fifo_rd_en && !bus.fifo_empty) pops++;
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        prev_beat_cyc = last_beat_cyc;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(bus.out_data), 64'(e[31:0]));
          check("beat_keep", 64'(bus.out_keep), 64'(e[35:32]));
        end
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
      prev_keep  = bus.out_keep;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(posedge rd_clk); #1;
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge rd_clk);
    tick(3);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_fill(input string name, input logic [FW-1:0] n);
    for (int i = 0; i < 100 && dbg_fill != n; i++) tick(1);
    check(name, 64'(dbg_fill), 64'(n));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b [4];
    int          rdy_mode;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int p0, b0;

    vecs[0].b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD}; vecs[0].rdy_mode = 0; vecs[0].exp_word = 32'hDDCCBBAA;
    vecs[1].b = '{8'h12, 8'h34, 8'h56, 8'h78}; vecs[1].rdy_mode = 0; vecs[1].exp_word = 32'h78563412;
    vecs[2].b = '{8'hFF, 8'h00, 8'hFF, 8'h00}; vecs[2].rdy_mode = 1; vecs[2].exp_word = 32'h00FF00FF;
    vecs[3].b = '{8'h01, 8'h80, 8'h7F, 8'hFE}; vecs[3].rdy_mode = 1; vecs[3].exp_word = 32'hFE7F8001;

    // ---- reset state ----
    tick(3);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_keep",  64'(bus.out_keep),  64'd0);
    check("rst_state",     64'(dbg_state),     64'd0);
    check("rst_fill",      64'(dbg_fill),      64'd0);
    mem[wr_ptr[7:0]] = 8'hEE;
    wr_ptr++;
    #1;
    check("rst_rd_en_nonempty", 64'(bus.fifo_rd_en), 64'd0);
    tick(2);
    rst_n = 1'b1;

    // ---- table: one word per vector, 4 pops each ----
    for (int v = 0; v < 4; v++) begin
      rdy_mode = vecs[v].rdy_mode;
      p0 = pops;
      exp_q.push_back({4'hF, vecs[v].exp_word});
      for (int k = 0; k < 4; k++) write_byte(vecs[v].b[k]);
      wait_drain($sformatf("vec%0d_drain", v));
      check($sformatf("vec%0d_pops", v), 64'(pops - p0), 64'd4);
      check($sformatf("vec%0d_state", v), 64'(dbg_state), 64'd0);
    end

    // ---- backpressure: two words, slot held ----
    rdy_mode = 2;
    tick(2);
    p0 = pops;
    exp_q.push_back({4'hF, 32'h44332211});
    exp_q.push_back({4'hF, 32'h88776655});
    for (int k = 1; k <= 8; k++) write_byte(8'((k << 4) | k));
    tick(20);
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    check("bp_data",  64'(bus.out_data),  64'h44332211);
    check("bp_fill",  64'(dbg_fill),      64'd4);
    check("bp_pops",  64'(pops - p0),     64'd8);
    write_byte(8'h99);
    tick(10);
    check("bp_no_pop_nonempty", 64'(bus.fifo_rd_en), 64'd0);
    check("bp_data_held", 64'(bus.out_data), 64'h44332211);
    rdy_mode = 0;
    wait_drain("bp_drain");
    check("bp_back_to_back", 64'(last_beat_cyc - prev_beat_cyc), 64'd1);
    exp_q.push_back({4'hF, 32'h9C9B9A99});
    write_byte(8'h9A); write_byte(8'h9B); write_byte(8'h9C);
    wait_drain("bp_tail_drain");

    // ---- FIFO runs dry mid-word ----
    write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
    tick(10);
    quiet_watch = 1'b1;
    tick(50);
    quiet_watch = 1'b0;
    check("dry_quiet", 64'(quiet_viol), 64'd0);
    check("dry_fill",  64'(dbg_fill),   64'd3);
    exp_q.push_back({4'hF, 32'h04030201});
    write_byte(8'h04);
    wait_drain("dry_drain");

    // ---- asynchronous reset mid-fill ----
    rdy_mode = 2;
    tick(2);
    for (int k = 0; k < 6; k++) write_byte(8'h61 + 8'(k));
    wait_fill("arst_prefill", 3'd2);
    check("arst_pre_valid", 64'(bus.out_valid), 64'd1);
    @(posedge rd_clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_data",  64'(bus.out_data),  64'd0);
    check("arst_fill",  64'(dbg_fill),      64'd0);
    mem[wr_ptr[7:0]] = 8'hEE;
    wr_ptr++;
    #1;
    check("arst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    rdy_mode = 0;
    exp_q.push_back({4'hF, 32'h40302010});
    write_byte(8'h10); write_byte(8'h20); write_byte(8'h30); write_byte(8'h40);
    wait_drain("arst_refill_drain");

`ifdef FIFO_RD_PACK_FLUSH_EN
    // ---- flush of a partial word, then an empty flush ----
    write_byte(8'h5A); write_byte(8'hA5);
    wait_fill("flush_prefill", 3'd2);
    exp_q.push_back({4'b0011, 32'h0000A55A});
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_drain("flush_drain");
    check("flush_fill", 64'(dbg_fill), 64'd0);
    b0 = beats;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(10);
    check("flush_empty_no_beat", 64'(beats - b0), 64'd0);
`else
    b0 = beats;
    tick(5);
    check("idle_no_beat", 64'(beats - b0), 64'd0);
`endif

    // ---- final report ----
    check("proto_rd_en_while_empty", 64'(proto_viol), 64'd0);
    check("stall_stability",         64'(stab_viol),  64'd0);
    check("exp_q_residual",          64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
